encoder_16_4: RTL
=================

# encoder_16_4

Sequential 16-to-4 event encoder: the inverse of the existing 4-to-16 one-hot decoder. Captures single-cycle event pulses on 16 input lines, queues them as sticky pending bits, and emits them one at a time as 4-bit codes over a valid/ready handshake. Fixed-priority or round-robin selection. Sits between a bank of interrupt/event sources and any consumer that takes a binary index, e.g. a decoder_4_16 driving an acknowledge bus.

## Interface
- ROUND_ROBIN, 1: 1 = round-robin selection starting after the last emitted code; 0 = fixed priority, lowest index first.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- insig  in  16  event pulses; any number of bits may be high in one cycle.
- out_code  out  4  binary index of the presented event.
- out_valid  out  1  out_code holds a presented event.
- out_ready  in  1  consumer accepts; a transfer occurs on a cycle with out_valid && out_ready.
- pending  out  16  captured events not yet presented; the presented bit is excluded.
- overflow  out  1  one-cycle pulse: an event arrived on a bit already pending and was merged.

## Operation
- State: pending[15:0], out_code, out_valid, rr_ptr[3:0] (next search start), overflow.
- Candidates: cand = pending | insig. The input bypasses into selection in the same cycle.
- Load condition: load = !out_valid || out_ready.
- On load with cand != 0:
  - out_code <= sel(cand), out_valid <= 1.
  - pending <= cand & ~onehot(sel).
  - With ROUND_ROBIN=1, rr_ptr <= sel + 1 (mod 16, 4-bit wrap; 15 wraps to 0).
- On load with cand == 0: out_valid <= 0, out_code holds, pending <= 0.
- No load (out_valid && !out_ready): out_code and out_valid hold, pending <= pending | insig.
- sel, fixed mode: lowest set index of cand.
- sel, round-robin mode: first set index scanning rr_ptr, rr_ptr+1, …, wrapping mod 16. rr_ptr is ignored when ROUND_ROBIN=0.
- onehot(sel) comes from a decoder_4_16 instance.
- overflow <= |(insig & pending), registered. A new event on the bit currently presented is not an overflow: it re-sets pending and is emitted again later.
- Events are never lost except by merging into an already-pending bit.
- Reset values: pending=0, out_code=0, out_valid=0, rr_ptr=0, overflow=0. Reset mid-operation discards all pending and presented events immediately and asynchronously.

## Timing
- Latency: an insig pulse in cycle N with the output idle gives out_valid=1 and out_code valid in cycle N+1.
- Back-to-back: with out_ready held high and pending non-empty, one code is emitted per cycle with no bubble.
- out_code and out_valid are stable while out_valid && !out_ready.
- out_valid never drops without a transfer.
- out_ready is ignored while out_valid=0.
- pending reflects insig one cycle later. overflow asserts the cycle after the colliding insig.
- Simultaneous transfer and new event on the same bit as the transferred code: that bit is eligible for the very next selection.

## Structure
- Shared package encoder_pkg:
  - constants N_IN=16, CODE_W=4;
  - function fixed_sel(vec) returning the lowest set index.
- Sub-module: decoder_4_16 instantiated for onehot(sel).
- Round-robin search implemented as rotate-right by rr_ptr, then fixed_sel, then add rr_ptr mod 16.
- All state in one always block with async reset.

## Test plan
- Reset, then insig=16'h0001 for one cycle with out_ready=1 -> next cycle out_valid=1, out_code=0; following cycle out_valid=0, pending=0.
- Fixed mode (ROUND_ROBIN=0), insig=16'h8421 for one cycle, out_ready=1 -> out_code 0, 5, 10, 15 on four consecutive cycles, then out_valid=0.
- Round-robin, insig=16'hFFFF once, out_ready=1 -> codes 0..15 in order. A second insig=16'h0003 after code 0 was emitted yields 1 (already queued), …, then 0 and 1 again in wrap order; no code is repeated before the wrap.
- Backpressure: out_ready=0, insig=16'h0010 -> out_code=4 held for 10 cycles. insig=16'h0010 again during the stall -> pending=16'h0010, no overflow. A third pulse -> overflow pulse. After out_ready=1: code 4 twice total.
- Simultaneous: while presenting code 3 with out_ready=1, insig=16'h0008 -> next cycle out_code=3, out_valid=1.
- Reset asserted mid-burst with pending=16'h00F0 -> out_valid, pending and overflow are 0 immediately, without waiting for a clock edge. After release, no codes are emitted until new events arrive.

Source files
------------

// File: rtl/encoder_pkg.sv
// encoder_pkg: shared constants and helpers for the 16-to-4 event encoder.
//   N_IN      - number of event input lines
//   CODE_W    - width of the binary event index
//   fixed_sel - lowest set index of a vector (0 when the vector is empty)
package encoder_pkg;

    localparam int unsigned N_IN   = 16;
    localparam int unsigned CODE_W = 4;

    // Scan from the top down so the lowest set bit is the last one written.
    function automatic logic [CODE_W-1:0] fixed_sel(input logic [N_IN-1:0] vec);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/decoder_4_16.sv
// decoder_4_16: 4-to-16 one-hot decoder.
//   code   in  4   binary index
//   onehot out 16  one-hot vector with bit [code] set
module decoder_4_16
    import encoder_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [N_IN-1:0]   onehot
);

    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/encoder_16_4.sv
// encoder_16_4: sequential 16-to-4 event encoder.
// Captures single-cycle pulses on insig as sticky pending bits and presents them one at a
// time as a binary code over a valid/ready handshake.
//   ROUND_ROBIN  param  1 = round-robin starting after the last emitted code,
//                       0 = fixed priority, lowest index first
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   insig        in   16  event pulses, any number per cycle
//   out_code     out  4   index of the presented event
//   out_valid    out  1   out_code holds a presented event
//   out_ready    in   1   consumer accepts; transfer on out_valid && out_ready
//   pending      out  16  captured events not yet presented (presented bit excluded)
//   overflow     out  1   one-cycle pulse: an event merged into an already-pending bit
module encoder_16_4
    import encoder_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   insig,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_IN-1:0]   pending,
    output logic              overflow
);

    logic [N_IN-1:0]   pending_q, pending_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic [CODE_W-1:0] rr_ptr_q, rr_ptr_d;
    logic              overflow_q, overflow_d;

    logic [N_IN-1:0]   cand;
    logic              load;
    logic [2*N_IN-1:0] cand_dbl;
    logic [N_IN-1:0]   cand_rot;
    logic [CODE_W-1:0] sel;
    logic [N_IN-1:0]   sel_onehot;

    // Selection: new inputs bypass straight into the candidate set.
    always_comb begin
        cand     = pending_q | insig;
        load     = !valid_q || out_ready;
        // Rotate right by rr_ptr so the search start lands at bit 0.
        cand_dbl = {cand, cand};
        cand_rot = cand_dbl[rr_ptr_q +: N_IN];
        if (ROUND_ROBIN) begin
            sel = fixed_sel(cand_rot) + rr_ptr_q;
        end else begin
            sel = fixed_sel(cand);
        end
    end

    decoder_4_16 u_sel_dec (
        .code   (sel),
        .onehot (sel_onehot)
    );

    always_comb begin
        pending_d  = pending_q;
        code_d     = code_q;
        valid_d    = valid_q;
        rr_ptr_d   = rr_ptr_q;
        // The presented bit is not in pending_q, so a repeat on it re-queues instead.
        overflow_d = |(insig & pending_q);

        if (load) begin
            if (|cand) begin
                code_d    = sel;
                valid_d   = 1'b1;
                pending_d = cand & ~sel_onehot;
                if (ROUND_ROBIN) begin
                    rr_ptr_d = sel + CODE_W'(1);
                end
            end else begin
                valid_d   = 1'b0;
                pending_d = '0;
            end
        end else begin
            pending_d = pending_q | insig;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_code  = code_q;
    assign out_valid = valid_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule
